// File: rtl/display_pkg.sv
// Shared definitions for the keypad digit display.
// SEG_BLANK: active-low pattern with every segment off.
// hex_t: one decoded keypad value.
// hex_to_seg: 16-entry active-low table, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] hex_t;

  function automatic logic [6:0] hex_to_seg(input hex_t h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Free-running digit scan timer.
// clk/reset: design clock, async active-high reset.
// index_o: position currently being scanned.
// dead_o:  high on the first cycle of each dwell, which is the dead-time cycle.
module scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [$clog2(NUM_DIGITS)-1:0] index_o,
  output logic                          dead_o
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(DWELL_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  // Next dwell count and scan index; the index moves only on a dwell wrap.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
      cnt_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign index_o = idx_q;
  assign dead_o  = (cnt_q == '0);

endmodule

// File: rtl/seg_decoder.sv
// Combinational hex-to-seven-segment decoder (active-low).
// hex_i: value to show; seg_o: {g,f,e,d,c,b,a}, 0 = segment lit.
module seg_decoder
  import display_pkg::*;
(
  input  hex_t       hex_i,
  output logic [6:0] seg_o
);

  // Table lookup.
  always_comb begin
    seg_o = hex_to_seg(hex_i);
  end

endmodule

// File: rtl/keypad_digit_display.sv
// N-digit keypad entry buffer with time-multiplexed seven-segment output.
// clk/reset: design clock, async active-high reset.
// num_valid/num: new key strobe and value; backspace/clear: edit strobes.
// segs: active-low {g..a}, registered; disp: one-hot position enable, registered,
// bit 0 = newest digit; digit_count/full: registered buffer occupancy.
module keypad_digit_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50,
  parameter int BLANK_UNUSED = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            num_valid,
  input  logic [3:0]                      num,
  input  logic                            backspace,
  input  logic                            clear,
  output logic [6:0]                      segs,
  output logic [NUM_DIGITS-1:0]           disp,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            full
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int KW = $clog2(NUM_DIGITS + 1);

  hex_t [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [KW-1:0]         count_q, count_d;
  logic                  full_q;
  logic [IW-1:0]         idx_s;
  logic                  dead_s;
  logic [6:0]            seg_s;
  logic                  blank_s;
  logic [6:0]            segs_q;
  logic [NUM_DIGITS-1:0] disp_q;

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .index_o(idx_s),
    .dead_o (dead_s)
  );

  seg_decoder u_dec (
    .hex_i(dig_q[idx_s]),
    .seg_o(seg_s)
  );

  // Buffer edit: clear wins, then replace-in-place, then push, then backspace.
  always_comb begin
    dig_d   = dig_q;
    count_d = count_q;
    if (clear) begin
      dig_d   = '0;
      count_d = '0;
    end else if (num_valid && backspace) begin
      dig_d[0] = num;
      if (count_q == '0) begin
        count_d = KW'(1);
      end else begin
        count_d = count_q;
      end
    end else if (num_valid) begin
      dig_d = {dig_q[NUM_DIGITS-2:0], num};
      if (count_q != KW'(NUM_DIGITS)) begin
        count_d = count_q + KW'(1);
      end else begin
        count_d = count_q;
      end
    end else if (backspace) begin
      if (count_q != '0) begin
        dig_d   = {4'h0, dig_q[NUM_DIGITS-1:1]};
        count_d = count_q - KW'(1);
      end else begin
        dig_d   = dig_q;
        count_d = count_q;
      end
    end else begin
      dig_d   = dig_q;
      count_d = count_q;
    end
  end

  // Positions at or beyond the entered count are shown dark when blanking is on.
  always_comb begin
    if (BLANK_UNUSED != 0) begin
      blank_s = (32'(idx_s) >= 32'(count_q));
    end else begin
      blank_s = 1'b0;
    end
  end

  // Buffer, occupancy and display output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      segs_q  <= SEG_BLANK;
      disp_q  <= '0;
    end else begin
      dig_q   <= dig_d;
      count_q <= count_d;
      full_q  <= (count_d == KW'(NUM_DIGITS));
      if (dead_s) begin
        segs_q <= SEG_BLANK;
        disp_q <= '0;
      end else begin
        segs_q <= blank_s ? SEG_BLANK : seg_s;
        disp_q <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_s;
      end
    end
  end

  assign segs        = segs_q;
  assign disp        = disp_q;
  assign digit_count = count_q;
  assign full        = full_q;

endmodule

// File: tb/tb_keypad_digit_display.sv
module tb_keypad_digit_display;

  localparam int N  = 4;
  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       num_valid, backspace, clear;
  logic [3:0] num;
  logic [6:0] segs;
  logic [N-1:0] disp;
  logic [2:0] digit_count;
  logic       full;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: newest digit at q[0]; count is q.size().
  int q[$];
  int tick;

  typedef struct {
    bit       nv;
    bit [3:0] val;
    bit       bs;
    bit       clr;
    int       cnt;
    bit       ful;
  } vec_t;

  vec_t vecs[18];

  keypad_digit_display #(
    .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_UNUSED(1)
  ) dut (
    .clk(clk), .reset(reset), .num_valid(num_valid), .num(num),
    .backspace(backspace), .clear(clear), .segs(segs), .disp(disp),
    .digit_count(digit_count), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict outputs from the pre-edge model state,
  // advance the model, then compare.
  task automatic step(input bit nv, input int val, input bit bs, input bit clr);
    int p, idx, c;
    logic [6:0]   e_segs;
    logic [N-1:0] e_disp;
    num_valid = nv; num = 4'(val); backspace = bs; clear = clr;
    @(posedge clk);
    tick++;
    p   = (tick - 1) % (N * DW);
    idx = p / DW;
    c   = p % DW;
    if (c == 0) begin
      e_disp = '0;
      e_segs = 7'h7F;
    end else begin
      e_disp = N'(1) << idx;
      e_segs = (idx < q.size()) ? hex7(q[idx]) : 7'h7F;
    end
    if (clr) q.delete();
    else if (nv && bs) begin
      if (q.size() == 0) q.push_front(val); else q[0] = val;
    end else if (nv) begin
      q.push_front(val);
      if (q.size() > N) void'(q.pop_back());
    end else if (bs) begin
      if (q.size() > 0) void'(q.pop_front());
    end
    #1;
    chk("disp", 32'(disp), 32'(e_disp));
    chk("segs", 32'(segs), 32'(e_segs));
    chk("digit_count", 32'(digit_count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == N));
    num_valid = 1'b0; backspace = 1'b0; clear = 1'b0;
  endtask

  initial begin
    bit found;
    num_valid = 1'b0; num = 4'h0; backspace = 1'b0; clear = 1'b0;
    reset = 1'b1;
    tick = 0;
    #22;
    chk("rst_disp", 32'(disp), 32'h0);
    chk("rst_segs", 32'(segs), 32'h7F);
    chk("rst_count", 32'(digit_count), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    reset = 1'b0;

    vecs[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1, 1'b0};
    vecs[1]  = '{1'b1, 4'h2, 1'b0, 1'b0, 2, 1'b0};
    vecs[2]  = '{1'b1, 4'h3, 1'b0, 1'b0, 3, 1'b0};
    vecs[3]  = '{1'b1, 4'h4, 1'b0, 1'b0, 4, 1'b1};
    vecs[4]  = '{1'b1, 4'h5, 1'b0, 1'b0, 4, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4, 1'b1};
    vecs[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0};
    vecs[7]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1, 1'b0};
    vecs[8]  = '{1'b1, 4'h2, 1'b0, 1'b0, 2, 1'b0};
    vecs[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 0, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 0, 1'b0};
    vecs[12] = '{1'b1, 4'hA, 1'b1, 1'b0, 1, 1'b0};
    vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0};
    vecs[14] = '{1'b1, 4'h1, 1'b0, 1'b0, 1, 1'b0};
    vecs[15] = '{1'b1, 4'h2, 1'b0, 1'b0, 2, 1'b0};
    vecs[16] = '{1'b1, 4'h3, 1'b0, 1'b0, 3, 1'b0};
    vecs[17] = '{1'b1, 4'h9, 1'b1, 1'b0, 3, 1'b0};
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].nv, int'(vecs[i].val), vecs[i].bs, vecs[i].clr);
      chk($sformatf("vec%0d_count", i), 32'(digit_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].ful));
    end
    // Buffer now {9,2,1}: scan a full period so every position is compared.
    for (int i = 0; i < N * DW; i++) step(1'b0, 0, 1'b0, 1'b0);
    // Clear together with a key: clear wins.
    step(1'b1, 7, 1'b0, 1'b1);
    chk("clr_nv_count", 32'(digit_count), 32'h0);

    // Enter 1,2,3; unentered position 3 is driven but dark.
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1'b0, 0, 1'b0, 1'b0);
      if (disp == 4'b1000) found = 1'b1;
    end
    chk("found_idx3", 32'(found), 32'h1);
    chk("idx3_blank", 32'(segs), 32'h7F);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1'b0, 0, 1'b0, 1'b0);
      if (disp == 4'b0001) found = 1'b1;
    end
    chk("found_idx0", 32'(found), 32'h1);
    chk("idx0_newest", 32'(segs), 32'h30);

    // Randomised edits against the model.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 45, int'($urandom_range(0, 15)), (r >= 30 && r < 60), (r >= 95));
    end

    // Asynchronous reset mid-dwell with three digits held.
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("arst_disp", 32'(disp), 32'h0);
    chk("arst_segs", 32'(segs), 32'h7F);
    chk("arst_count", 32'(digit_count), 32'h0);
    chk("arst_full", 32'(full), 32'h0);
    #3 reset = 1'b0;
    q.delete();
    tick = 0;
    step(1'b0, 0, 1'b0, 1'b0);
    chk("post_rst_dead", 32'(disp), 32'h0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("post_rst_idx0", 32'(disp), 32'h1);
    for (int i = 0; i < 2 * N * DW; i++) step(1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_digit_display.md
Name: keypad_digit_display

Overview:
Parametrised N-digit entry buffer and time-multiplexed seven-segment driver. It replaces the fixed two-digit hold/shift registers and two-display toggle in the keypad top level. It accepts decoded hex key strobes from the keypad scanner and keeps the last NUM_DIGITS entries, with backspace and clear. It scans the digits onto a common segment bus with a dead-time between digits and optional blanking of unentered positions.

Parameters:
NUM_DIGITS, 4, number of display positions and buffer depth; must be >= 2.
DWELL_CYCLES, 50, clk cycles each position is selected, including the dead-time cycle; must be >= 2.
BLANK_UNUSED, 1, 1 = positions not yet entered show all segments off; 0 = they show 0.

Ports:
clk  input  1  design clock (slow fsm clock domain).
reset  input  1  asynchronous, active-high reset.
num_valid  input  1  single-cycle strobe: new key value on num.
num  input  4  hex key value, sampled when num_valid=1.
backspace  input  1  single-cycle strobe: remove the most recent digit.
clear  input  1  single-cycle strobe: empty the buffer.
segs  output  7  {g,f,e,d,c,b,a}, active-low, registered.
disp  output  NUM_DIGITS  one-hot position enable, active-high, registered; bit 0 = most recent digit.
digit_count  output  $clog2(NUM_DIGITS+1)  number of valid digits entered.
full  output  1  digit_count == NUM_DIGITS.

Behaviour:
- Reset (async, active-high): all buffer entries 0, digit_count 0, full 0, scan index 0, dwell counter 0, disp all 0, segs 7'h7F (blank). Takes effect immediately, mid-dwell or mid-update.
- Buffer: entries d[0..N-1]; d[0] is the newest digit.
- Update priority, evaluated each posedge:
  - clear: all d = 0, count = 0. Overrides everything else in the same cycle.
  - num_valid with backspace in the same cycle: replace in place, d[0] = num, others unchanged. count = max(count, 1).
  - num_valid alone: shift, d[i] = d[i-1], d[0] = num. The oldest entry is dropped when full. count saturates at N.
  - backspace alone: shift down, d[i] = d[i+1], d[N-1] = 0. count decrements, saturating at 0. With count = 0 there is no change.
- full and digit_count are registered with the buffer, so they are valid in the cycle after the update edge.
- Scan timer:
  - dwell counter runs 0..DWELL_CYCLES-1, then wraps to 0.
  - On the wrap, the index advances modulo NUM_DIGITS, so N-1 goes to 0.
  - The timer runs freely and is independent of buffer updates.
- Dead-time: while the dwell counter is 0, the registered outputs are disp = 0 and segs = 7'h7F.
- Drive cycles (dwell counter 1..DWELL_CYCLES-1): disp = one-hot(index).
  - segs = active-low hex encoding of d[index].
  - If BLANK_UNUSED=1 and index >= digit_count, segs = 7'h7F instead; disp is still asserted.
- Latency: outputs are registered from the current counter, index and buffer. A buffer change is visible on segs 1 cycle after its update edge, provided the position is being driven.
- Full scan period: NUM_DIGITS*DWELL_CYCLES cycles.
- Hex encoding, active-low: 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, F = 7'h0E (standard 16-entry table).

Decomposition:
- Shared package (display_pkg):
  - SEG_BLANK = 7'h7F.
  - typedef hex_t = logic [3:0].
  - The 16-entry active-low segment table as a constant function.
- Sub-module scan_timer:
  - Holds the dwell counter and index.
  - Outputs index and a dead-time flag.
  - Parameters NUM_DIGITS and DWELL_CYCLES.
- Buffer update logic and output registers stay in keypad_digit_display.
- Hex-to-segment conversion uses the existing seg_decoder.

Test Plan:
1. N=4, DWELL=4. Reset, then strobe num = 1, 2, 3 on separate cycles -> d = {3,2,1,0}, count = 3, full = 0. During index 3 drive cycles, disp = 4'b1000 and segs = 7'h7F.
2. Strobe 1, 2, 3, 4, 5 -> d = {5,4,3,2}, count = 4, full = 1. Digit 1 is dropped.
3. From d = {2,1}, count = 2: backspace -> d = {1,0,0,0}, count = 1. Backspace twice more -> count = 0, and the second backspace changes nothing.
4. From d = {3,2,1}:
   - num_valid=1, num=9, backspace=1 -> d = {9,2,1}, count = 3.
   - Next cycle, clear=1 and num_valid=1 -> all 0, count = 0.
5. Scan timing, DWELL=4: disp sequence 0000, 0001 x3, 0000, 0010 x3, 0000, 0100 x3, 0000, 1000 x3, repeating every 16 cycles. segs = 7'h7F in every disp = 0 cycle.
6. Assert reset asynchronously mid-dwell with count = 3 -> disp = 0, segs = 7'h7F, count = 0 before the next clk edge. After release, the scan restarts at index 0 with a dead-time cycle.
